data_mem_arbiter: RTL
=====================

// Module: data_mem_arbiter
//
// PURPOSE
// Arbitrates one single-port data memory (async read, write on posedge clk when MW=1, word-indexed)
// between two requesters: port A (CPU load/store stage) and port B (program loader / debug port).
// Grants one transaction at a time, round-robin. Drives the memory's addr/MW/datain, returns
// registered read data with a one-cycle ack pulse, and flags out-of-range word addresses.
//
// PARAMETERS
// DATA_W     32  data word width
// ADDR_W     32  word-address width on requester and memory ports
// MEM_DEPTH  64  words implemented in the memory; addr >= MEM_DEPTH is out of range
//
// PORTS
// clk        in   1       clock, all state on posedge
// rst        in   1       synchronous reset, active high
// a_req      in   1       A request; hold high with a_we/a_addr/a_wdata stable until a_ack
// a_we       in   1       A: 1 = write, 0 = read
// a_addr     in   ADDR_W  A word address
// a_wdata    in   DATA_W  A write data
// a_ack      out  1       A one-cycle completion pulse
// a_err      out  1       A out-of-range flag, valid with a_ack
// a_rdata    out  DATA_W  A read data, valid with a_ack, held until A's next ack
// b_*        same set as a_* for requester B
// mem_addr   out  ADDR_W  to memory addr
// mem_mw     out  1       to memory MW
// mem_din    out  DATA_W  to memory datain
// mem_dout   in   DATA_W  from memory dataout (combinational read)
// busy       out  1       high in any state other than IDLE
//
// BEHAVIOUR
// - FSM IDLE -> ACCESS -> RESP -> IDLE; one transaction per 3 cycles, req-to-ack latency 2 edges.
// - IDLE: sample a_req/b_req. None: stay. One: grant it. Both: grant the port not granted last
//   (last_grant resets to B, so A wins the first tie). On grant edge capture granted port's
//   we/addr/wdata into internal regs, set range_ok = (addr < MEM_DEPTH), go ACCESS.
// - ACCESS: mem_addr/mem_din = captured regs; mem_mw = we & range_ok & !rst. At the edge: memory
//   writes (if mem_mw); rdata reg <= range_ok ? mem_dout : 0 (also on writes: returns old word);
//   err reg <= !range_ok; go RESP.
// - RESP: granted port's ack=1 for exactly this cycle, its rdata/err updated; other port's ack=0
//   and its rdata/err unchanged. Requests not sampled in RESP. Next state IDLE unconditionally.
// - A requester keeping req high after ack issues a new transaction, sampled in the next IDLE.
// - mem_mw=0 in IDLE and RESP; mem_addr/mem_din hold captured regs in all states (no glitch mux).
// - Out-of-range: no write, rdata=0, err=1, ack still given. Addresses are never wrapped/truncated.
// - Requester changing addr/we/wdata after grant has no effect on the current transaction.
// - Reset values: state=IDLE, busy=0, a_ack=b_ack=0, a_err=b_err=0, a_rdata=b_rdata=0,
//   mem_mw=0, mem_addr=0, mem_din=0, last_grant=B.
// - rst in any state (incl. ACCESS/RESP): no write at that edge, no ack afterwards, transaction
//   dropped; requester must re-present it. Memory contents not cleared.
//
// TESTING
// 1 Reset: rst=1 two cycles with a_req=1,a_we=1 -> mem_mw never 1, no ack, all outputs 0.
// 2 A write then read: a_we=1,a_addr=5,a_wdata=0xDEADBEEF; then a_we=0,a_addr=5 -> 2nd a_ack
//   has a_rdata=0xDEADBEEF, a_err=0; mem_mw high exactly one cycle, in ACCESS of 1st txn.
// 3 Tie: a_req=b_req=1 held, reads of addr 1 (A) / 2 (B) -> acks alternate A,B,A,B every 3
//   cycles, a_rdata=1, b_rdata=2 (default memory init word i = i).
// 4 Out of range: b_we=1,b_addr=64,b_wdata=7 -> b_ack with b_err=1, b_rdata=0, mem_mw stays 0;
//   later read addr 63 -> 63 unchanged.
// 5 Reset mid-op: rst=1 in ACCESS of an A write to addr 10 -> no a_ack, word 10 still 10.
// 6 Stability: change a_addr 3->9 in ACCESS of a read of 3 -> a_rdata=3; B's rdata untouched.

Source files
------------

// File: rtl/data_mem_arbiter.sv
// Round-robin arbiter giving two requesters (A: CPU, B: loader/debug) turns on one
// single-port data memory; one transaction per IDLE->ACCESS->RESP pass.
module data_mem_arbiter #(
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned ADDR_W    = 32,
  parameter int unsigned MEM_DEPTH = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              a_req,
  input  logic              a_we,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [DATA_W-1:0] a_wdata,
  output logic              a_ack,
  output logic              a_err,
  output logic [DATA_W-1:0] a_rdata,
  input  logic              b_req,
  input  logic              b_we,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [DATA_W-1:0] b_wdata,
  output logic              b_ack,
  output logic              b_err,
  output logic [DATA_W-1:0] b_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_mw,
  output logic [DATA_W-1:0] mem_din,
  input  logic [DATA_W-1:0] mem_dout,
  output logic              busy
);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  state_t            state_q, state_d;
  logic              last_b_q, last_b_d;
  logic              sel_b_q, sel_b_d;
  logic              we_q, we_d;
  logic              ok_q, ok_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] a_rdata_q, a_rdata_d, b_rdata_q, b_rdata_d;
  logic              a_err_q, a_err_d, b_err_q, b_err_d;
  logic              grant_b;

  always_comb begin
    state_d   = state_q;
    last_b_d  = last_b_q;
    sel_b_d   = sel_b_q;
    we_d      = we_q;
    ok_d      = ok_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    a_rdata_d = a_rdata_q;
    b_rdata_d = b_rdata_q;
    a_err_d   = a_err_q;
    b_err_d   = b_err_q;
    grant_b   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (a_req || b_req) begin
          // B wins only when A is absent or A was the previous winner
          grant_b  = b_req && (!a_req || !last_b_q);
          sel_b_d  = grant_b;
          last_b_d = grant_b;
          we_d     = grant_b ? b_we    : a_we;
          addr_d   = grant_b ? b_addr  : a_addr;
          wdata_d  = grant_b ? b_wdata : a_wdata;
          ok_d     = addr_d < ADDR_W'(MEM_DEPTH);
          state_d  = ACCESS;
        end
      end
      ACCESS: begin
        if (sel_b_q) begin
          b_rdata_d = ok_q ? mem_dout : '0;
          b_err_d   = !ok_q;
        end else begin
          a_rdata_d = ok_q ? mem_dout : '0;
          a_err_d   = !ok_q;
        end
        state_d = RESP;
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      last_b_q  <= 1'b1;
      sel_b_q   <= 1'b0;
      we_q      <= 1'b0;
      ok_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      a_rdata_q <= '0;
      b_rdata_q <= '0;
      a_err_q   <= 1'b0;
      b_err_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      last_b_q  <= last_b_d;
      sel_b_q   <= sel_b_d;
      we_q      <= we_d;
      ok_q      <= ok_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      a_rdata_q <= a_rdata_d;
      b_rdata_q <= b_rdata_d;
      a_err_q   <= a_err_d;
      b_err_q   <= b_err_d;
    end
  end

  // Memory bus is driven straight from the captured regs so it never glitches
  assign mem_addr = addr_q;
  assign mem_din  = wdata_q;
  assign mem_mw   = (state_q == ACCESS) && we_q && ok_q && !rst;
  assign a_ack    = (state_q == RESP) && !sel_b_q;
  assign b_ack    = (state_q == RESP) && sel_b_q;
  assign a_rdata  = a_rdata_q;
  assign b_rdata  = b_rdata_q;
  assign a_err    = a_err_q;
  assign b_err    = b_err_q;
  assign busy     = (state_q != IDLE);

endmodule
